rsc_term_encoder: RTL
=====================

RSC_TERM_ENCODER -- requirements
Module: rsc_term_encoder

Interface
REQ-001 Parameter K, default 40: information block length in bits, range 8..6144.
REQ-002 Parameter MSB_FIRST, default 1: 1 means din[K-1] is encoded first; 0 means din[0] is encoded first.
REQ-003 clk  input  1  single rising-edge clock for all state.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request to load din and begin encoding; sampled in IDLE only.
REQ-006 din  input  K  information block, captured in the cycle start is accepted.
REQ-007 busy  output  1  high from start acceptance until DONE exits.
REQ-008 out_valid  output  1  sys_out, par_out and out_tail are valid.
REQ-009 out_ready  input  1  downstream accepts the current output bit when high with out_valid.
REQ-010 sys_out  output  1  systematic bit, or tail systematic bit.
REQ-011 par_out  output  1  parity bit, or tail parity bit.
REQ-012 out_tail  output  1  current output is a trellis-termination bit.
REQ-013 done  output  1  one-cycle pulse after the last output transfer.
REQ-014 state_out  output  3  encoder shift register {s1,s2,s3}, where s1 is the newest bit.

Function
REQ-015 The encoder SHALL be the LTE/NB-IoT 8-state constituent code with feedback g0=1+D^2+D^3 and feedforward g1=1+D+D^3.
- Feedback a = u^s2^s3.
- Parity z = a^s1^s3.
- Update on transfer: s1<=a, s2<=s1, s3<=s2.
REQ-016 FSM states SHALL be IDLE, ENC, TAIL and DONE.
- IDLE->ENC on start.
- ENC->TAIL after the K-th transfer.
- TAIL->DONE after the 3rd tail transfer.
- DONE->IDLE unconditionally the next cycle.
REQ-017 On start in IDLE, the block SHALL capture din into a K-bit shift register, clear the bit counter and state, and assert busy.
- out_valid rises in the following cycle (latency 1) with the first bit.
REQ-018 In ENC, out_valid SHALL stay high.
- sys_out is the current information bit u.
- par_out is z.
- out_tail is 0.
REQ-019 A transfer occurs only when out_valid and out_ready are both high.
- Without a transfer, sys_out, par_out, out_tail, state_out and the counter SHALL hold stable.
REQ-020 In TAIL, the input SHALL be u=s2^s3, so a=0.
- sys_out is u.
- par_out is s1^s3.
- out_tail is 1.
- After 3 transfers, state_out is 000.
REQ-021 The bit counter SHALL be ceil(log2(K+3)) bits wide and SHALL never wrap within a block.
- It terminates ENC at exactly count K-1 transferred.
REQ-022 start SHALL be ignored while busy, including in DONE.
- A start in the cycle DONE returns to IDLE is also ignored; start is accepted only in IDLE.
REQ-023 done SHALL pulse for exactly one cycle, in DONE, with out_valid low.
REQ-024 Total transfers per block SHALL be K+3 with RSC_TAIL_EN defined, and K without it.

Reset
REQ-025 While rst is high, the block SHALL be in IDLE with all outputs 0: busy, out_valid, sys_out, par_out, out_tail, done and state_out=000.
REQ-026 Reset asserted mid-block SHALL abort immediately.
- No done pulse is generated.
- The first start after reset release begins a fresh block.

Configuration
REQ-027 Macro RSC_TAIL_EN: when defined, the TAIL state and the 3-step termination SHALL be built.
- When undefined, ENC goes directly to DONE after K transfers.
- The final state is left unflushed on state_out.
- out_tail is tied to 0.

Structure
REQ-028 Package rsc_pkg SHALL hold:
- the FSM state enum;
- constants G0=4'b1011 and G1=4'b1101;
- constant N_TAIL=3;
- the counter-width function.
REQ-029 Sub-module rsc_trellis_step SHALL be the combinational single step.
- Inputs: u, state, tail.
- Outputs: sys, par, next_state.
- It is instantiated once.

Verification
REQ-030 K=40, din=0, out_ready=1.
- Expect 43 transfers, all sys/par 0.
- Expect out_tail high on the last 3.
- Expect done one cycle after the last transfer.
REQ-031 K=40, MSB_FIRST=1, din=40'h8000000000.
- First four par_out bits 1,1,1,1.
- First sys_out 1, remaining sys_out 0.
REQ-032 K=40, din=40'h5555555555.
- Output stream and 3 tail pairs match a bit-exact golden model.
- state_out=000 after the tail.
REQ-033 Drive out_ready low for 5 cycles mid-ENC.
- Outputs and state_out stay frozen.
- Stream resumes with no lost or duplicated bits.
REQ-034 Assert rst at transfer 20.
- All outputs 0 within the reset cycle.
- No done pulse.
- The next start yields the full 43-transfer block.
REQ-035 Pulse start during ENC and during DONE.
- Both ignored; busy profile unchanged.
- Rebuild without RSC_TAIL_EN and confirm exactly 40 transfers with out_tail always 0.

Source files
------------

// File: rtl/rsc_pkg.sv
// Shared types and constants for the LTE/NB-IoT 8-state RSC encoder.
package rsc_pkg;

  typedef enum logic [1:0] {S_IDLE, S_ENC, S_TAIL, S_DONE} rsc_state_e;

  // Polynomial taps, MSB = D^0 ... LSB = D^3
  localparam logic [3:0] G0 = 4'b1011;
  localparam logic [3:0] G1 = 4'b1101;
  localparam int N_TAIL = 3;

  function automatic int cnt_width(input int k);
    return $clog2(k + N_TAIL);
  endfunction

endpackage

// File: rtl/rsc_trellis_step.sv
// Single combinational trellis step; in tail mode the input is forced so the feedback cancels.
module rsc_trellis_step
  import rsc_pkg::*;
(
  input  logic       u,
  input  logic [2:0] state,
  input  logic       tail,
  output logic       sys,
  output logic       par,
  output logic [2:0] next_state
);
  logic s1, s2, s3, fb, u_eff, a;

  always_comb begin
    {s1, s2, s3} = state;
    fb    = (G0[2] & s1) ^ (G0[1] & s2) ^ (G0[0] & s3);
    u_eff = tail ? fb : u;
    a     = u_eff ^ fb;
    sys   = u_eff;
    par   = (G1[3] & a) ^ (G1[2] & s1) ^ (G1[1] & s2) ^ (G1[0] & s3);
    next_state = {a, s1, s2};
  end
endmodule

// File: rtl/rsc_term_encoder.sv
// RSC constituent encoder with valid/ready bit stream; trellis termination built
// only when RSC_TAIL_EN is defined.
module rsc_term_encoder
  import rsc_pkg::*;
#(
  parameter int K         = 40,
  parameter bit MSB_FIRST = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [K-1:0] din,
  output logic         busy,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         sys_out,
  output logic         par_out,
  output logic         out_tail,
  output logic         done,
  output logic [2:0]   state_out
);
  localparam int CW = cnt_width(K);
  localparam logic [CW-1:0] LAST_ENC = CW'(K - 1);

  rsc_state_e     fsm_q, fsm_d;
  logic [K-1:0]   sr_q, sr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2:0]     st_q, st_d, st_nxt;
  logic           cur_u, in_tail, sys_w, par_w, xfer;

  assign cur_u = MSB_FIRST ? sr_q[K-1] : sr_q[0];
`ifdef RSC_TAIL_EN
  localparam logic [CW-1:0] LAST_TAIL = CW'(K + N_TAIL - 1);
  assign in_tail = (fsm_q == S_TAIL);
`else
  assign in_tail = 1'b0;
`endif

  rsc_trellis_step u_step (
    .u(cur_u), .state(st_q), .tail(in_tail),
    .sys(sys_w), .par(par_w), .next_state(st_nxt)
  );

  assign out_valid = (fsm_q == S_ENC) || in_tail;
  assign xfer      = out_valid & out_ready;
  assign busy      = (fsm_q != S_IDLE);
  assign done      = (fsm_q == S_DONE);
  assign sys_out   = out_valid & sys_w;
  assign par_out   = out_valid & par_w;
  assign out_tail  = in_tail;
  assign state_out = st_q;

  always_comb begin
    fsm_d = fsm_q;
    sr_d  = sr_q;
    cnt_d = cnt_q;
    st_d  = st_q;
    case (fsm_q)
      S_IDLE: if (start) begin
        fsm_d = S_ENC;
        sr_d  = din;
        cnt_d = '0;
        st_d  = '0;
      end
      S_ENC: if (xfer) begin
        st_d  = st_nxt;
        sr_d  = MSB_FIRST ? {sr_q[K-2:0], 1'b0} : {1'b0, sr_q[K-1:1]};
        cnt_d = cnt_q + CW'(1);
`ifdef RSC_TAIL_EN
        if (cnt_q == LAST_ENC) fsm_d = S_TAIL;
`else
        if (cnt_q == LAST_ENC) fsm_d = S_DONE;
`endif
      end
`ifdef RSC_TAIL_EN
      S_TAIL: if (xfer) begin
        st_d  = st_nxt;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_TAIL) fsm_d = S_DONE;
      end
`endif
      default: fsm_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q <= S_IDLE;
      sr_q  <= '0;
      cnt_q <= '0;
      st_q  <= '0;
    end else begin
      fsm_q <= fsm_d;
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
      st_q  <= st_d;
    end
  end
endmodule
